crypto1_key_reader: RTL and testbench

- Host-side end of the serial key-readout interface of the Crypto1 search cores.
- Monitors NCORES search cores and selects each core that finished with a valid key.
- Drives that core's key clock 48 times and deserialises its key MSB-first.
- Presents the 48-bit key and the core index on a valid/ready port to the host/UART bridge. Signals when the whole search space is exhausted.

---
 rtl/crypto1_key_reader_pkg.sv | 26 ++
 rtl/crypto1_key_reader_if.sv | 25 ++
 rtl/crypto1_key_shifter.sv | 74 +++++++
 rtl/crypto1_key_reader.sv | 120 ++++++++++++
 tb/tb_crypto1_key_reader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/crypto1_key_reader_pkg.sv
// Shared types for the Crypto1 key readout path: key width, reader state encoding
// and the lowest-index priority encoder used to pick the next core to read.
package crypto1_pkg;

  localparam int KEY_WIDTH = 48;
  localparam int MAX_CORES = 256;

  typedef enum logic [2:0] {
    SCAN,
    PULSE,
    SAMPLE,
    PRESENT,
    EXHAUSTED
  } keyrd_state_t;

  // Scans from the top down so the last hit, i.e. the lowest set index, wins.
  function automatic logic [7:0] lowestSetIdx(input logic [MAX_CORES-1:0] vec);
    logic [7:0] idx;
    idx = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[7:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/crypto1_key_reader_if.sv
// Host-facing key port of the Crypto1 key reader: key, source core index,
// valid/ready handshake and the end-of-search flags.
interface crypto1_key_reader_if #(
  parameter int IDXW = 1
);
  import crypto1_pkg::*;

  logic [KEY_WIDTH-1:0] key;
  logic [IDXW-1:0]      key_idx;
  logic                 key_valid;
  logic                 key_ready;
  logic                 all_done;
  logic                 not_found;

  modport master (
    output key, key_idx, key_valid, all_done, not_found,
    input  key_ready
  );

  modport slave (
    input  key, key_idx, key_valid, all_done, not_found,
    output key_ready
  );

endinterface

// File: rtl/crypto1_key_shifter.sv
// Bit-serial key capture: paces key-clock pulses, samples the returned bit a cycle
// later (plus SETTLE idle cycles) and shifts 48 bits MSB-first into the key register.
module crypto1_key_shifter
  import crypto1_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_bit,
  output logic                 o_pulseNext,
  output logic                 o_done,
  output logic [KEY_WIDTH-1:0] o_key
);

  keyrd_state_t         r_state;
  logic [5:0]           r_bitCnt;
  logic [3:0]           r_settleCnt;
  logic [KEY_WIDTH-1:0] r_shift;
  logic                 r_done;
  logic                 w_settled;
  logic                 w_lastBit;

  assign w_settled = (r_settleCnt == 4'(SETTLE));
  assign w_lastBit = (r_bitCnt == 6'd47);

  // Tells the owner of the key-clock register that a pulse must appear next cycle.
  assign o_pulseNext = ((r_state == SCAN) && i_start) ||
                       ((r_state == SAMPLE) && w_settled && !w_lastBit);
  assign o_done = r_done;
  assign o_key  = r_shift;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= SCAN;
      r_bitCnt    <= '0;
      r_settleCnt <= '0;
      r_shift     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SCAN: begin
          if (i_start) begin
            r_state  <= PULSE;
            r_bitCnt <= '0;
          end
        end
        PULSE: begin
          r_state     <= SAMPLE;
          r_settleCnt <= '0;
        end
        SAMPLE: begin
          // The core's bit is fresh on the first SAMPLE cycle; extra cycles only pad.
          if (r_settleCnt == 4'd0) r_shift <= {r_shift[KEY_WIDTH-2:0], i_bit};
          if (w_settled) begin
            if (w_lastBit) begin
              r_state <= SCAN;
              r_done  <= 1'b1;
            end else begin
              r_bitCnt <= r_bitCnt + 6'd1;
              r_state  <= PULSE;
            end
          end else begin
            r_settleCnt <= r_settleCnt + 4'd1;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

endmodule

// File: rtl/crypto1_key_reader.sv
// Host-side Crypto1 key reader: picks finished cores with a key, reads each key out
// serially and hands it to the host. Optional macro KEYREAD_FIRST_ONLY_EN stops after one key.
module crypto1_key_reader
  import crypto1_pkg::*;
#(
  parameter int NCORES = 256,
  parameter int SETTLE = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NCORES-1:0] i_coreDone,
  input  logic [NCORES-1:0] i_coreKeyValid,
  input  logic [NCORES-1:0] i_coreKeyData,
  output logic [NCORES-1:0] o_coreKeyClk,
  crypto1_key_reader_if.master host
);

  localparam int IDXW = (NCORES > 1) ? $clog2(NCORES) : 1;

  keyrd_state_t         r_state;
  logic [NCORES-1:0]    r_mask;
  logic [NCORES-1:0]    r_coreKeyClk;
  logic [IDXW-1:0]      r_idx;
  logic                 r_keyValid;
  logic                 r_allDone;
  logic                 r_notFound;
  logic [7:0]           r_keyCount;

  logic [NCORES-1:0]    w_cand;
  logic                 w_candFound;
  logic [IDXW-1:0]      w_candIdx;
  logic [IDXW-1:0]      w_nextIdx;
  logic                 w_start;
  logic                 w_pulseNext;
  logic                 w_shiftDone;
  logic                 w_accept;
  logic [KEY_WIDTH-1:0] w_key;

  assign w_cand      = i_coreDone & i_coreKeyValid & ~r_mask;
  assign w_candFound = |w_cand;
  assign w_candIdx   = IDXW'(lowestSetIdx(MAX_CORES'(w_cand)));
  assign w_start     = (r_state == SCAN) && w_candFound;
  assign w_nextIdx   = w_start ? w_candIdx : r_idx;
  assign w_accept    = r_keyValid && host.key_ready;

  crypto1_key_shifter #(
    .SETTLE(SETTLE)
  ) u_shifter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (w_start),
    .i_bit      (i_coreKeyData[r_idx]),
    .o_pulseNext(w_pulseNext),
    .o_done     (w_shiftDone),
    .o_key      (w_key)
  );

  assign o_coreKeyClk   = r_coreKeyClk;
  assign host.key       = w_key;
  assign host.key_idx   = r_idx;
  assign host.key_valid = r_keyValid;
  assign host.all_done  = r_allDone;
  assign host.not_found = r_notFound;

  // The shifter sequences PULSE/SAMPLE itself; this FSM simply parks in PULSE until it finishes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= SCAN;
      r_mask       <= '0;
      r_coreKeyClk <= '0;
      r_idx        <= '0;
      r_keyValid   <= 1'b0;
      r_allDone    <= 1'b0;
      r_notFound   <= 1'b0;
      r_keyCount   <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        r_coreKeyClk[i] <= w_pulseNext && (w_nextIdx == IDXW'(i));
      end
      case (r_state)
        SCAN: begin
          if (w_candFound) begin
            r_idx   <= w_candIdx;
            r_state <= PULSE;
          end else if (&i_coreDone) begin
            r_state    <= EXHAUSTED;
            r_allDone  <= 1'b1;
            r_notFound <= (r_keyCount == 8'd0);
          end
        end
        PULSE, SAMPLE: begin
          if (w_shiftDone) begin
            r_state    <= PRESENT;
            r_keyValid <= 1'b1;
          end
        end
        PRESENT: begin
          if (w_accept) begin
            r_keyValid <= 1'b0;
            for (int i = 0; i < NCORES; i++) begin
              if (IDXW'(i) == r_idx) r_mask[i] <= 1'b1;
            end
            if (r_keyCount != 8'hFF) r_keyCount <= r_keyCount + 8'd1;
`ifdef KEYREAD_FIRST_ONLY_EN
            r_state    <= EXHAUSTED;
            r_allDone  <= 1'b1;
            r_notFound <= 1'b0;
`else
            r_state <= SCAN;
`endif
          end
        end
        EXHAUSTED: begin
        end
        default: r_state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto1_key_reader.sv
// Directed bench for crypto1_key_reader: two 4-core readers (SETTLE 0 and 3) driven
// by behavioural serial-key cores, with hand-computed expected keys and timings.
module tb_crypto1_key_reader;
  import crypto1_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, rstB;
  logic [3:0] doneA, validA, dataA, kclkA;
  logic [3:0] doneB, validB, dataB, kclkB;

  crypto1_key_reader_if #(.IDXW(2)) hostA ();
  crypto1_key_reader_if #(.IDXW(2)) hostB ();

  crypto1_key_reader #(.NCORES(4), .SETTLE(0)) dutA (
    .i_clk(clk), .i_reset(rstA), .i_coreDone(doneA), .i_coreKeyValid(validA),
    .i_coreKeyData(dataA), .o_coreKeyClk(kclkA), .host(hostA)
  );

  crypto1_key_reader #(.NCORES(4), .SETTLE(3)) dutB (
    .i_clk(clk), .i_reset(rstB), .i_coreDone(doneB), .i_coreKeyValid(validB),
    .i_coreKeyData(dataB), .o_coreKeyClk(kclkB), .host(hostB)
  );

  int checks = 0;
  int failures = 0;

  logic [47:0] coreKeyA [4];
  logic [47:0] coreKeyB [4];
  int coreCntA [4];
  int coreCntB [4];
  int pulseCntA [4];
  int pulseCntB [4];
  int violA = 0;
  logic [3:0] prevKclkA = '0;

  // Behavioural cores: each key-clock pulse registers the next key bit, MSB first.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rstA) begin
        coreCntA[i] <= 0; dataA[i] <= 1'b0; pulseCntA[i] <= 0;
      end else if (kclkA[i]) begin
        if (coreCntA[i] < 48) dataA[i] <= coreKeyA[i][47 - coreCntA[i]];
        coreCntA[i] <= coreCntA[i] + 1;
        pulseCntA[i] <= pulseCntA[i] + 1;
      end
      if (rstB) begin
        coreCntB[i] <= 0; dataB[i] <= 1'b0; pulseCntB[i] <= 0;
      end else if (kclkB[i]) begin
        if (coreCntB[i] < 48) dataB[i] <= coreKeyB[i][47 - coreCntB[i]];
        coreCntB[i] <= coreCntB[i] + 1;
        pulseCntB[i] <= pulseCntB[i] + 1;
      end
    end
    if (!rstA && (((kclkA & prevKclkA) != 4'd0) || ($countones(kclkA) > 1))) violA <= violA + 1;
    prevKclkA <= kclkA;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit useB, input logic [3:0] done, input logic [3:0] valid);
    @(negedge clk);
    if (useB) begin doneB = done; validB = valid; end
    else begin doneA = done; validA = valid; end
  endtask

  task automatic resetA();
    @(negedge clk);
    rstA = 1'b1; doneA = '0; validA = '0; hostA.key_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstA = 1'b0;
  endtask

  task automatic waitValid(input bit useB, input int budget, output int lat);
    lat = 0;
    while (!(useB ? hostB.key_valid : hostA.key_valid) && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput(useB ? "validSeenB" : "validSeenA",
                64'(useB ? hostB.key_valid : hostA.key_valid), 64'd1);
  endtask

  task automatic handshakeA();
    @(negedge clk);
    hostA.key_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("acceptClearsValid", 64'(hostA.key_valid), 64'd0);
    @(negedge clk);
    hostA.key_ready = 1'b0;
  endtask

  int lat, sp, pulsesBefore, budget;
  bit stable;
  logic [47:0] snapKey;
  logic [1:0]  snapIdx;

  initial begin
    rstA = 1'b1; rstB = 1'b1;
    doneA = '0; validA = '0; doneB = '0; validB = '0;
    hostA.key_ready = 1'b0; hostB.key_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin coreKeyA[i] = '0; coreKeyB[i] = '0; end

    // Reset values
    resetA();
    #1;
    checkOutput("rstKey", 64'(hostA.key), 64'd0);
    checkOutput("rstIdx", 64'(hostA.key_idx), 64'd0);
    checkOutput("rstValid", 64'(hostA.key_valid), 64'd0);
    checkOutput("rstAllDone", 64'(hostA.all_done), 64'd0);
    checkOutput("rstNotFound", 64'(hostA.not_found), 64'd0);
    checkOutput("rstKeyClk", 64'(kclkA), 64'd0);

    // Single core 2 key, latency, hold while not ready
    coreKeyA[2] = 48'hA0A1A2A3A4A5;
    applyStimulus(1'b0, 4'b1111, 4'b0100);
    @(posedge clk); #1;
    checkOutput("firstPulseCore2", 64'(kclkA), 64'h4);
    waitValid(1'b0, 300, lat);
    checkOutput("latency1", 64'(lat), 64'd97);
    checkOutput("key1", 64'(hostA.key), 64'hA0A1A2A3A4A5);
    checkOutput("idx1", 64'(hostA.key_idx), 64'd2);
    checkOutput("allDoneWhilePresent", 64'(hostA.all_done), 64'd0);
    snapKey = hostA.key; snapIdx = hostA.key_idx;
    pulsesBefore = pulseCntA[0] + pulseCntA[1] + pulseCntA[2] + pulseCntA[3];
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (hostA.key !== snapKey || hostA.key_idx !== snapIdx || hostA.key_valid !== 1'b1) stable = 1'b0;
    end
    checkOutput("holdStable", 64'(stable), 64'd1);
    checkOutput("holdNoPulses", 64'(pulseCntA[0] + pulseCntA[1] + pulseCntA[2] + pulseCntA[3]),
                64'(pulsesBefore));
    handshakeA();
    repeat (2) @(posedge clk); #1;
    checkOutput("allDone1", 64'(hostA.all_done), 64'd1);
    checkOutput("notFound1", 64'(hostA.not_found), 64'd0);
    checkOutput("pulsesCore2", 64'(pulseCntA[2]), 64'd48);
    checkOutput("pulsesOthers", 64'(pulseCntA[0] + pulseCntA[1] + pulseCntA[3]), 64'd0);
    checkOutput("pulseShape", 64'(violA), 64'd0);

    // Cores 1 and 3 simultaneously: ascending order
    coreKeyA[1] = 48'h000000000001;
    coreKeyA[3] = 48'hFFFFFFFFFFFF;
    resetA();
    applyStimulus(1'b0, 4'b1111, 4'b1010);
    @(posedge clk); #1;
    waitValid(1'b0, 300, lat);
    checkOutput("keyCore1", 64'(hostA.key), 64'h1);
    checkOutput("idxCore1", 64'(hostA.key_idx), 64'd1);
    checkOutput("allDoneAfterFirstPending", 64'(hostA.all_done), 64'd0);
    handshakeA();
`ifdef KEYREAD_FIRST_ONLY_EN
    repeat (2) @(posedge clk); #1;
    checkOutput("firstOnlyAllDone", 64'(hostA.all_done), 64'd1);
    checkOutput("firstOnlyNotFound", 64'(hostA.not_found), 64'd0);
    checkOutput("firstOnlyCore3Idle", 64'(pulseCntA[3]), 64'd0);
`else
    waitValid(1'b0, 300, lat);
    checkOutput("keyCore3", 64'(hostA.key), 64'hFFFFFFFFFFFF);
    checkOutput("idxCore3", 64'(hostA.key_idx), 64'd3);
    checkOutput("allDoneBeforeSecond", 64'(hostA.all_done), 64'd0);
    handshakeA();
    repeat (2) @(posedge clk); #1;
    checkOutput("allDone2", 64'(hostA.all_done), 64'd1);
    checkOutput("notFound2", 64'(hostA.not_found), 64'd0);
`endif
    checkOutput("pulseShape2", 64'(violA), 64'd0);

    // No valid keys anywhere
    resetA();
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    repeat (2) @(posedge clk); #1;
    checkOutput("emptyAllDone", 64'(hostA.all_done), 64'd1);
    checkOutput("emptyNotFound", 64'(hostA.not_found), 64'd1);
    checkOutput("emptyNoPulses", 64'(pulseCntA[0] + pulseCntA[1] + pulseCntA[2] + pulseCntA[3]), 64'd0);

    // SETTLE=3 reader: pulse spacing, reset mid-shift, re-read from bit 47
    coreKeyB[0] = 48'h123456789ABC;
    @(negedge clk);
    rstB = 1'b0;
    applyStimulus(1'b1, 4'b0001, 4'b0001);
    @(posedge clk); #1;
    checkOutput("firstPulseB", 64'(kclkB), 64'h1);
    sp = 0;
    do begin
      @(posedge clk); #1;
      sp++;
    end while (!kclkB[0] && sp < 20);
    checkOutput("pulseSpacingB", 64'(sp), 64'd5);
    budget = 0;
    while (pulseCntB[0] < 21 && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("reachBit20", 64'(pulseCntB[0] >= 21), 64'd1);
    @(negedge clk);
    rstB = 1'b1;
    @(posedge clk); #1;
    checkOutput("midRstKeyClk", 64'(kclkB), 64'd0);
    checkOutput("midRstKey", 64'(hostB.key), 64'd0);
    checkOutput("midRstValid", 64'(hostB.key_valid), 64'd0);
    checkOutput("midRstIdx", 64'(hostB.key_idx), 64'd0);
    @(negedge clk);
    rstB = 1'b0;
    @(posedge clk); #1;
    waitValid(1'b1, 400, lat);
    checkOutput("latencyB", 64'(lat), 64'd241);
    checkOutput("keyB", 64'(hostB.key), 64'h123456789ABC);
    checkOutput("idxB", 64'(hostB.key_idx), 64'd0);
    checkOutput("pulsesB", 64'(pulseCntB[0]), 64'd48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
